seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle iterative integer divider for the CPU datapath. It covers the inverse of the ALU's add/subtract work and is built from a single shared subtractor. The core asserts `start` with two operands and receives quotient, remainder and a divide-by-zero flag after a fixed latency. The block serves `div`/`divu`-class instructions, which the single-cycle ALU cannot execute.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: operand and result width. It must be ≥ 2, and the iteration count equals `DATA_WIDTH`.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  request strobe. It is sampled on a rising edge and accepted only when `busy` is 0.
- `signed_op`  input  1  1 selects signed (two's complement) division, 0 selects unsigned. Sampled with `start`.
- `dividend`  input  DATA_WIDTH  sampled with `start`.
- `divisor`  input  DATA_WIDTH  sampled with `start`.
- `busy`  output  1  high while an operation is in flight. Start requests are ignored while it is high.
- `done`  output  1  one-cycle pulse; results are valid from this cycle onward.
- `quotient`  output  DATA_WIDTH  result. It holds its value until the next accepted start completes.
- `remainder`  output  DATA_WIDTH  result, held the same way as `quotient`.
- `div_zero`  output  1  set with `done` when the divisor was 0. It holds its value like the results.

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1:
  - Latch `signed_op`, the dividend sign (`sd`) and the quotient sign (`sq` = dividend sign XOR divisor sign). Both signs are 0 when unsigned.
  - Latch the operand magnitudes: the absolute value if signed, otherwise the raw operand.
  - Clear the partial remainder and set iteration counter = 0.
  - Divisor == 0 → go to DONE. Otherwise go to CALC.
- CALC is restoring division, one quotient bit per cycle, MSB first:
  - Form `t = {rem[W-2:0], dq[W-1]}`, where `dq` is the dividend-magnitude shift register.
  - Compute `t - |divisor|` with one (W+1)-bit subtractor.
  - If there is no borrow, rem = difference and the new quotient bit = 1. Otherwise rem = t and the quotient bit = 0.
  - Shift `dq` left, inserting the quotient bit at the LSB.
  - After W iterations (counter reaches W-1), go to FIX.
- FIX:
  - quotient = `sq` ? −q : q.
  - remainder = `sd` ? −rem : rem.
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle, then go to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero. The remainder sign follows the dividend, and |remainder| < |divisor|.
  - Magnitudes are held as W-bit unsigned values, so |MIN_INT| = 2^(W-1) is represented exactly.
  - Signed MIN_INT / −1 → quotient = MIN_INT (wraps), remainder = 0, no flag.
- Divide by zero:
  - quotient = all ones, remainder = the raw dividend, `div_zero` = 1.
  - Applies to both signed and unsigned operations.
- For every non-zero divisor, `div_zero` = 0 with the result.

## Timing

- Reset (`rst_n`=0, asynchronous, at any time, including mid-CALC):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0.
  - Counter and internal registers are cleared.
  - The in-flight operation is discarded, with no `done`.
- `busy` = 1 in CALC and FIX, and 0 in IDLE and DONE.
- Normal latency:
  - `start` is sampled at edge E0.
  - CALC covers E1..E(W), FIX is at E(W+1), and DONE is the cycle after E(W+1).
  - So `done` is high after edge W+1, i.e. 33 cycles after the start edge for W=32.
- Divide-by-zero latency: `done` is high the cycle after the start edge (DONE entered directly).
- Back-to-back: `start` asserted during the `done` cycle is accepted, because `busy`=0. The new operation begins and the previous results stay stable until the new FIX/DONE update.
- `start` while `busy`=1 is ignored entirely, and the operands are not re-sampled.
- Results update only at the FIX edge (or the start edge for divide-by-zero). They are stable during `done` and afterwards.

## Test plan

- Unsigned: 100 / 7 → `done` 33 cycles after start, quotient=14, remainder=2, `div_zero`=0. Then 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0.
- Signed sign combinations:
  - −7 / 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1).
  - 7 / −2 → quotient −3, remainder 1.
  - −7 / −2 → quotient 3, remainder −1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned same operands → quotient=0, remainder=0x80000000.
- Divide by zero: 1234 / 0 (signed and unsigned) → `done` one cycle after start, quotient=0xFFFFFFFF, remainder=1234, `div_zero`=1. The next valid division clears `div_zero`.
- Handshake:
  - `start` pulsed mid-operation with different operands → ignored, and the original result is returned.
  - `start` during the `done` cycle → accepted, with the second `done` exactly 33 cycles later.
- Reset: deassert `rst_n` asynchronously at cycle 15 of CALC → all outputs 0 immediately, no `done`. After release, 9 / 3 yields quotient=3, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per cycle through a single shared subtractor.
// Signed operands are divided as magnitudes, and the signs are applied in the FIX state.
module seq_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  signed_op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  div_zero
);
   localparam int W = DATA_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [W-1:0] dq, rem, dvs, t, dd_mag, dv_mag;
   logic [W:0] diff;
   logic sq, sd;
   assign dd_mag = (signed_op && dividend[W-1]) ? -dividend : dividend;
   assign dv_mag = (signed_op && divisor[W-1]) ? -divisor : divisor;
   // The partial remainder stays below 2^(W-1) before every shift, so dropping its MSB is lossless.
   assign t = {rem[W-2:0], dq[W-1]};
   assign diff = {1'b0, t} - {1'b0, dvs};
   assign busy = (state == CALC) || (state == FIX);
   assign done = state == DONE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         dq <= '0;
         rem <= '0;
         dvs <= '0;
         sq <= 1'b0;
         sd <= 1'b0;
         quotient <= '0;
         remainder <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            CALC: begin
               rem <= diff[W] ? t : diff[W-1:0];
               dq <= {dq[W-2:0], ~diff[W]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) state <= FIX;
            end
            FIX: begin
               quotient <= sq ? -dq : dq;
               remainder <= sd ? -rem : rem;
               div_zero <= 1'b0;
               state <= DONE;
            end
            default: begin
               if (start) begin
                  sd <= signed_op & dividend[W-1];
                  sq <= signed_op & (dividend[W-1] ^ divisor[W-1]);
                  dq <= dd_mag;
                  dvs <= dv_mag;
                  rem <= '0;
                  cnt <= '0;
                  if (divisor == '0) begin
                     quotient <= '1;
                     remainder <= dividend;
                     div_zero <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table, handshake/reset sequences and randomized operations
// checked against an arithmetic reference model.
module tb_seq_divider;
   localparam int W = 32;
   localparam int LAT = W + 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic signed_op = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic busy, done, div_zero;
   logic [W-1:0] quotient, remainder;
   int checks = 0;
   int failures = 0;

   seq_divider #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic sop;
      logic [W-1:0] a, b, q, r;
      logic z;
      int lat;
   } vec_t;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Divide-by-zero and sign rules; 64-bit arithmetic makes MIN_INT / -1 wrap naturally.
   task automatic model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == '0) begin
         q = '1; r = a; z = 1'b1;
      end else if (sop) begin
         q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endtask

   task automatic issue(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      signed_op = sop; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk);
   endtask

   // Returns the number of rising edges after the start edge until done is seen high.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      vec_t vt[10];
      int lat, seen;
      logic [W-1:0] eq, er, a, b;
      logic ez, sop;
      vt[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT};
      vt[1] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, LAT};
      vt[2] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT};
      vt[3] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, LAT};
      vt[4] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, LAT};
      vt[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, LAT};
      vt[6] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, LAT};
      vt[7] = '{1'b1, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 0};
      vt[8] = '{1'b0, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 0};
      vt[9] = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", W'(busy), 0);
      chk("reset_done", W'(done), 0);
      chk("reset_q", quotient, 0);
      chk("reset_r", remainder, 0);
      chk("reset_z", W'(div_zero), 0);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         issue(vt[i].sop, vt[i].a, vt[i].b);
         wait_done(lat);
         chk($sformatf("vec%0d_lat", i), W'(lat), W'(vt[i].lat));
         chk($sformatf("vec%0d_q", i), quotient, vt[i].q);
         chk($sformatf("vec%0d_r", i), remainder, vt[i].r);
         chk($sformatf("vec%0d_z", i), W'(div_zero), W'(vt[i].z));
         @(negedge clk);
         chk($sformatf("vec%0d_pulse", i), W'(done), 0);
         chk($sformatf("vec%0d_hold", i), quotient, vt[i].q);
      end

      // start pulsed mid-operation with other operands must be ignored
      issue(1'b0, 32'd100, 32'd7);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      signed_op = 1'b1; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      chk("ign_busy", W'(busy), 1);
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      chk("ign_lat", W'(lat + 6), W'(LAT));
      chk("ign_q", quotient, 32'd14);
      chk("ign_r", remainder, 32'd2);

      // start during the done cycle is accepted; old results hold until the new FIX
      signed_op = 1'b0; dividend = 32'd9; divisor = 32'd4; start = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_busy", W'(busy), 1);
      chk("b2b_hold_q", quotient, 32'd14);
      wait_done(lat);
      chk("b2b_lat", W'(lat), W'(LAT));
      chk("b2b_q", quotient, 32'd2);
      chk("b2b_r", remainder, 32'd1);

      // asynchronous reset during CALC discards the operation
      issue(1'b0, 32'd100, 32'd7);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", W'(busy), 0);
      chk("arst_done", W'(done), 0);
      chk("arst_q", quotient, 0);
      chk("arst_r", remainder, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("arst_no_done", W'(seen), 0);
      issue(1'b0, 32'd9, 32'd3);
      wait_done(lat);
      chk("arst_after_q", quotient, 32'd3);
      chk("arst_after_r", remainder, 32'd0);

      for (int n = 0; n < 300; n++) begin
         sop = 1'($urandom);
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = W'($urandom_range(1, 15));
            2: b = -W'($urandom_range(1, 15));
            3: b = 32'hFFFFFFFF;
            4: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         model(sop, a, b, eq, er, ez);
         issue(sop, a, b);
         wait_done(lat);
         chk($sformatf("rnd%0d_lat s=%0d a=%h b=%h", n, sop, a, b), W'(lat), (b == '0) ? 0 : W'(LAT));
         chk($sformatf("rnd%0d_q s=%0d a=%h b=%h", n, sop, a, b), quotient, eq);
         chk($sformatf("rnd%0d_r s=%0d a=%h b=%h", n, sop, a, b), remainder, er);
         chk($sformatf("rnd%0d_z s=%0d a=%h b=%h", n, sop, a, b), W'(div_zero), W'(ez));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
